// File: rtl/tff_stream_decoder_if.sv
// Stream bundle for tff_stream_decoder: T flip-flop line samples in, decoded words out.
interface tff_stream_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             q_in;
  logic             q_valid;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             par_err;

  modport master (
    output q_in, q_valid, sync, dout_ready,
    input  dout, dout_valid, overrun, par_err
  );

  modport slave (
    input  q_in, q_valid, sync, dout_ready,
    output dout, dout_valid, overrun, par_err
  );
endinterface

// File: rtl/tff_stream_decoder.sv
// Decodes a T flip-flop line (bit = level change) into WIDTH-bit words, LSB first.
// Optional even-parity trailer bit enabled by defining TFF_DEC_PARITY_EN.
module tff_stream_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  tff_stream_decoder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef TFF_DEC_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
`else
  typedef enum logic {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic             q_ref_q, q_ref_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             par_err_d;
  logic             complete_c;
  logic [WIDTH-1:0] word_c;
  logic             bit_c;

  // Next-state, word assembly and output register update
  always_comb begin
    state_d      = state_q;
    q_ref_d      = q_ref_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    par_err_d    = 1'b0;
    complete_c   = 1'b0;
    word_c       = sr_q;
    bit_c        = bus.q_in ^ q_ref_q;

    if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end

    // sync restarts framing from any state and outranks a same-cycle strobe
    if (bus.sync) begin
      q_ref_d   = bus.q_in;
      bit_cnt_d = '0;
      sr_d      = '0;
      overrun_d = 1'b0;
      state_d   = SHIFT;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (bus.q_valid) begin
            q_ref_d = bus.q_in;
            word_c  = sr_q | (WIDTH'(bit_c) << bit_cnt_q);
            if (bit_cnt_q == LAST_IDX) begin
`ifdef TFF_DEC_PARITY_EN
              sr_d      = word_c;
              bit_cnt_d = CNT_W'(WIDTH);
              state_d   = PAR;
`else
              complete_c = 1'b1;
              sr_d       = '0;
              bit_cnt_d  = '0;
`endif
            end else begin
              sr_d      = word_c;
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef TFF_DEC_PARITY_EN
        PAR: begin
          if (bus.q_valid) begin
            q_ref_d   = bus.q_in;
            sr_d      = '0;
            bit_cnt_d = '0;
            state_d   = SHIFT;
            if ((^sr_q) ^ bit_c) begin
              par_err_d = 1'b1;
            end else begin
              complete_c = 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // A full, unconsumed output register drops the new word
    if (complete_c) begin
      if (!dout_valid_q || bus.dout_ready) begin
        dout_d       = word_c;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      q_ref_q      <= 1'b0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_ref_q      <= q_ref_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef TFF_DEC_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign bus.par_err = par_err_q;
`else
  logic unused_par_c;
  assign unused_par_c = par_err_d;
  assign bus.par_err  = 1'b0;
`endif

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/tff_stream_decoder.md
TFF_STREAM_DECODER -- requirements
Module: tff_stream_decoder

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 q_in  input  1  line level from a T flip-flop encoder; each data bit equals the toggle (change) of this level.
REQ-005 q_valid  input  1  sample strobe; q_in is consumed only in cycles where q_valid=1.
REQ-006 sync  input  1  frame start; loads the reference level and restarts word assembly.
REQ-007 dout  output  WIDTH  decoded word, LSB is the first bit received.
REQ-008 dout_valid  output  1  dout holds an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-010 overrun  output  1  sticky flag: a completed word was dropped because the output register was full.
REQ-011 par_err  output  1  one-cycle pulse on a parity mismatch (see Configuration).

Function
REQ-012 States SHALL be IDLE, SHIFT and PAR; PAR exists only when the Configuration macro is defined.
REQ-013 IDLE: the block SHALL ignore q_valid; sync=1 -> q_ref<=q_in, bit_cnt<=0, overrun<=0, next state SHIFT.
REQ-014 SHIFT, q_valid=1: decoded bit b=q_in XOR q_ref; q_ref<=q_in; b SHALL shift into bit position bit_cnt; bit_cnt<=bit_cnt+1.
REQ-015 When the WIDTH-th bit is taken (without parity), the word SHALL complete in that cycle, bit_cnt<=0, and the state SHALL remain SHIFT (back-to-back words need no new sync).
REQ-016 Completed word: if dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle, dout<=word and dout_valid<=1 on the next edge. Latency is 1 cycle from the strobe carrying the last bit.
REQ-017 Completed word while dout_valid=1 and dout_ready=0: the word SHALL be dropped, dout unchanged, overrun<=1.
REQ-018 dout_valid=1 and dout_ready=1 with no completing word: dout_valid<=0 next cycle.
REQ-019 dout SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-020 sync=1 in SHIFT or PAR: the partial word SHALL be discarded, q_ref<=q_in, bit_cnt<=0, overrun<=0, state SHIFT; dout/dout_valid unaffected.
REQ-021 sync and q_valid in the same cycle: sync SHALL win; that q_in is used only as the reference, and no bit is decoded.
REQ-022 q_valid=0 cycles SHALL leave q_ref, bit_cnt and the shift register unchanged (arbitrary gaps between strobes).
REQ-023 bit_cnt SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never exceed WIDTH.

Reset
REQ-024 rst=0 at a rising edge: state<=IDLE, q_ref<=0, bit_cnt<=0, shift register<=0, dout<=0, dout_valid<=0, overrun<=0, par_err<=0.
REQ-025 Reset mid-word or with dout_valid=1 SHALL discard all data; no word is output until the next sync after rst returns to 1.
REQ-026 Reset SHALL take priority over sync, q_valid and dout_ready.

Configuration
REQ-027 Macro TFF_DEC_PARITY_EN defined: after the WIDTH-th data bit, state PAR; the next q_valid decodes one more bit as even parity (XOR of data bits XOR parity bit = 0), then the state returns to SHIFT.
REQ-028 With TFF_DEC_PARITY_EN and parity correct: the word SHALL be completed per REQ-016/017 in the parity-bit cycle. Parity wrong: the word SHALL be dropped, par_err=1 for exactly one cycle, and overrun is unchanged.
REQ-029 Without TFF_DEC_PARITY_EN: there is no PAR state, the word completes on the WIDTH-th bit, and par_err SHALL be tied to 0.

Verification
REQ-030 Reset with rst=0 for 2 cycles, then release -> all outputs 0; q_valid strobes without sync -> dout_valid stays 0.
REQ-031 WIDTH=8: sync with q_in=0, then 8 strobes with q_in=1,1,0,0,0,1,1,0 -> dout=0xA5, dout_valid=1 one cycle after the 8th strobe.
REQ-032 Two back-to-back words with dout_ready=0 -> first word held stable, overrun=1; dout_ready=1 -> dout_valid falls; next sync clears overrun.
REQ-033 Sync after 5 bits, then 8 fresh bits encoding 0x3C -> dout=0x3C, with no trace of the partial word; sync+q_valid in the same cycle -> no bit is counted.
REQ-034 With TFF_DEC_PARITY_EN: 0xA5 followed by parity bit 0 -> dout=0xA5; parity bit 1 -> no dout_valid, par_err high for 1 cycle.
REQ-035 rst=0 pulse after 4 bits with dout_valid=1 -> dout_valid=0, state IDLE; a new sync and a full word then decode correctly.
